// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_port
// Purpose  : Multi-cycle load/store port between the core datapath and the
//            data-memory request/acknowledge bus. One transaction at a time.
//            Generates byte enables and lane-replicated store data. Returns
//            aligned, sign- or zero-extended load data. Stalls the core while
//            a transaction is outstanding. Reports bus timeouts as faults.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES : REQ cycles without bus_ack before a fault (1..255)
// Optional build macro
//   LSU_MISALIGN_TRAP_EN : misaligned half/word accesses fault immediately
//                          without touching the bus
// Ports
//   clk_i          : clock, rising edge
//   rst_n_i        : synchronous active-low reset
//   req_valid_i    : core memory request, held until done_o
//   mem_write_i    : 1 = store, 0 = load
//   funct3_i[2:0]  : access width/sign (byte/half/word, signed/unsigned)
//   addr_i[31:0]   : byte address
//   wdata_i[31:0]  : store data
//   stall_o        : hold the pipeline
//   done_o         : one-cycle completion pulse
//   fault_o        : transaction failed (valid with done_o)
//   ReadData_o     : extended load result, held until the next done_o
//   bus_req_o      : bus request
//   bus_we_o       : bus write enable
//   bus_addr_o     : word-aligned bus address
//   bus_wdata_o    : lane-replicated store data
//   bus_be_o[3:0]  : byte enables
//   bus_ack_i      : bus completion
//   bus_rdata_i    : bus read data, valid with bus_ack_i
// ============================================================================
module lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] ReadData_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic        done_q;
  logic        fault_q;
  logic [31:0] rdata_q;

  // Values captured on acceptance, decoded from the live request inputs.
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        misalign_d;
  // Load result extracted from the bus using the latched width/offset.
  logic [31:0] rdata_d;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic        sext;

  // funct3[1:0]: 00 byte, 01 half, 1x word (undefined codes fall to word).
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_d = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      (funct3_i[1] && (addr_i[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  // Half accesses shift by addr[1] only, so addr[0] never affects the lane.
  always_comb begin
    sext = ~funct3_q[2];
    case (funct3_q[1:0])
      2'b00:   shamt = {off_q, 3'b000};
      2'b01:   shamt = {off_q[1], 4'b0000};
      default: shamt = 5'd0;
    endcase
    shifted = bus_rdata_i >> shamt;
    case (funct3_q[1:0])
      2'b00:   rdata_d = {{24{sext & shifted[7]}}, shifted[7:0]};
      2'b01:   rdata_d = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: rdata_d = shifted;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_be_q    <= 4'b0000;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            funct3_q    <= funct3_i;
            off_q       <= addr_i[1:0];
            bus_addr_q  <= {addr_i[31:2], 2'b00};
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            cnt_q       <= 8'd0;
            if (misalign_d) begin
              // Trap without a bus cycle; completion on the next cycle.
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              rdata_q <= 32'd0;
            end else begin
              state_q   <= ST_REQ;
              bus_req_q <= 1'b1;
              bus_we_q  <= mem_write_i;
            end
          end
        end
        ST_REQ: begin
          // An ack arriving on the limit cycle still completes normally.
          if (bus_ack_i) begin
            if (!bus_we_q) begin
              rdata_q <= rdata_d;
            end
            state_q   <= ST_RESP;
            done_q    <= 1'b1;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
          end else if (cnt_q == TIMEOUT_LIMIT) begin
            state_q   <= ST_RESP;
            done_q    <= 1'b1;
            fault_q   <= 1'b1;
            rdata_q   <= 32'd0;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Combinational so the core stalls in the very cycle it presents a request.
  assign stall_o     = ((state_q == ST_IDLE) && req_valid_i) || (state_q == ST_REQ);
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign ReadData_o  = rdata_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = bus_be_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_port
// Purpose  : Self-checking bench for lsu_mem_port with TIMEOUT_CYCLES = 4.
//            A transaction-level model derives the expected per-cycle outputs
//            from the access rules. A negedge compare process checks the DUT
//            against them. Literal checks pin the model and key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_port;

  localparam int TMO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall_o, done_o, fault_o, bus_req_o, bus_we_o;
  logic [31:0] ReadData_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  lsu_mem_port #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .mem_write_i (mem_write),
    .funct3_i    (funct3),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .fault_o     (fault_o),
    .ReadData_o  (ReadData_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_be_o    (bus_be_o),
    .bus_ack_i   (bus_ack),
    .bus_rdata_i (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the current cycle.
  bit          chk_en, e_zero, e_stall, e_req, e_done, e_fault, e_we, e_wd_chk, e_rd_chk;
  logic [31:0] e_addr, e_wd, e_rd;
  logic [3:0]  e_be;
  logic [31:0] model_rd;

  // Observations captured by the compare process.
  int          req_total = 0;
  int          done_cyc  = -1;
  logic [3:0]  last_be;
  logic [31:0] last_addr, last_wd;
  logic        last_we, last_fault;
  int          txn_start, req_snap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  function automatic int m_size(input logic [1:0] fw);
    if (fw == 2'b00) return 1;
    if (fw == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] fw, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (m_size(fw))
      1:       be[lo] = 1'b1;
      2:       be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] fw, input logic [31:0] d);
    case (m_size(fw))
      1:       return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2:       return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [1:0] lo, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    int          bo, ho;
    bo = int'(lo);
    ho = int'(lo[1]);
    b  = r[bo*8 +: 8];
    h  = r[ho*16 +: 16];
    case (m_size(f[1:0]))
      1:       return f[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2:       return f[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return r;
    endcase
  endfunction

  function automatic bit m_misalign(input logic [1:0] fw, input logic [1:0] lo);
    int sz;
    sz = m_size(fw);
    return TRAP_EN && (((sz == 2) && lo[0]) || ((sz == 4) && (lo != 2'b00)));
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (e_zero) begin
        chk("rst_stall", stall_o, 0);
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_bus_we", bus_we_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        chk("rst_bus_wdata", bus_wdata_o, 0);
        chk("rst_bus_be", bus_be_o, 0);
        chk("rst_ReadData", ReadData_o, 0);
      end else begin
        chk("stall", stall_o, e_stall);
        chk("bus_req", bus_req_o, e_req);
        chk("done", done_o, e_done);
        if (e_req) begin
          chk("bus_we", bus_we_o, e_we);
          chk("bus_addr", bus_addr_o, e_addr);
          chk("bus_be", bus_be_o, e_be);
        end
        if (e_wd_chk) chk("bus_wdata", bus_wdata_o, e_wd);
        if (e_done)   chk("fault", fault_o, e_fault);
        if (e_rd_chk) chk("ReadData", ReadData_o, e_rd);
      end
    end
    if (bus_req_o === 1'b1) begin
      req_total++;
      last_be   = bus_be_o;
      last_addr = bus_addr_o;
      last_wd   = bus_wdata_o;
      last_we   = bus_we_o;
    end
    if (done_o === 1'b1) begin
      done_cyc   = cyc;
      last_fault = fault_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    e_zero = 0; e_stall = 0; e_req = 0; e_done = 0; e_fault = 0; e_we = 0;
    e_wd_chk = 0; e_rd_chk = 0; e_addr = '0; e_wd = '0; e_rd = '0; e_be = '0;
  endtask

  // ack_at: REQ cycle index (0 = first REQ cycle) carrying bus_ack; -1 = never.
  task automatic txn(input bit w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rd, input int ack_at);
    bit mis, flt;
    int nreq;
    mis = m_misalign(f[1:0], a[1:0]);
    if (mis) begin
      nreq = 0; flt = 1;
    end else if (ack_at >= 0 && ack_at <= TMO) begin
      nreq = ack_at + 1; flt = 0;
    end else begin
      nreq = TMO + 1; flt = 1;
    end
    step();
    txn_start = cyc; req_snap = req_total;
    req_valid = 1; mem_write = w; funct3 = f; addr = a; wdata = d;
    bus_ack = 0; bus_rdata = $urandom;
    clear_exp(); e_stall = 1;
    for (int i = 1; i <= nreq; i++) begin
      step();
      bus_ack   = (i == ack_at + 1);
      bus_rdata = bus_ack ? rd : $urandom;
      clear_exp();
      e_stall = 1; e_req = 1; e_we = w;
      e_addr  = {a[31:2], 2'b00};
      e_be    = m_be(f[1:0], a[1:0]);
      e_wd    = m_wdata(f[1:0], d);
      e_wd_chk = w;
    end
    step();
    bus_ack = 1; bus_rdata = $urandom;   // stray ack in the response cycle
    if (flt) model_rd = 32'd0;
    else if (!w) model_rd = m_load(f, a[1:0], rd);
    clear_exp(); e_done = 1; e_fault = flt; e_rd = model_rd; e_rd_chk = !w || flt;
    step();
    req_valid = 0; bus_ack = 0;
    clear_exp(); e_rd = model_rd; e_rd_chk = !w || flt;
  endtask

  task automatic idle_ack();
    step();
    bus_ack = 1; bus_rdata = $urandom;
    clear_exp(); e_rd = model_rd; e_rd_chk = 1;
    step();
    bus_ack = 0;
    clear_exp(); e_rd = model_rd; e_rd_chk = 1;
  endtask

  initial begin
    rst_n = 0; req_valid = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
    bus_ack = 0; bus_rdata = 0; model_rd = 0; chk_en = 0;
    clear_exp();
    step();
    clear_exp(); e_zero = 1; chk_en = 1;
    step();
    rst_n = 1;

    // Model pins.
    chk("pin_lb",  m_load(3'b000, 2'b11, 32'h80FF_0012), 32'hFFFF_FF80);
    chk("pin_lhu", m_load(3'b101, 2'b10, 32'hBEEF_1234), 32'h0000_BEEF);
    chk("pin_sb",  m_wdata(2'b00, 32'h1234_56AB), 32'hABAB_ABAB);
    chk("pin_be",  m_be(2'b01, 2'b10), 4'b1100);

    // Load byte signed, ack on first REQ cycle.
    txn(0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0012, 0);
    chk("lb_ReadData", ReadData_o, 32'hFFFF_FF80);
    chk("lb_be", last_be, 4'b1000);
    chk("lb_addr", last_addr, 32'h0000_0100);
    chk("lb_latency", done_cyc - txn_start, 2);

    // Stray ack while idle is ignored.
    idle_ack();

    // Load half unsigned.
    txn(0, 3'b101, 32'h0000_0202, 32'h0, 32'hBEEF_1234, 2);
    chk("lhu_ReadData", ReadData_o, 32'h0000_BEEF);
    chk("lhu_be", last_be, 4'b1100);

    // Store byte.
    txn(1, 3'b000, 32'h0000_0001, 32'h1234_56AB, 32'h0, 1);
    chk("sb_we", last_we, 1);
    chk("sb_be", last_be, 4'b0010);
    chk("sb_wdata", last_wd, 32'hABAB_ABAB);

    // Timeout.
    txn(0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, -1);
    chk("tmo_fault", last_fault, 1);
    chk("tmo_ReadData", ReadData_o, 32'h0);
    chk("tmo_latency", done_cyc - txn_start, TMO + 2);

    // Ack on the limit cycle wins over the timeout.
    txn(0, 3'b001, 32'h0000_0010, 32'h0, 32'h0000_8001, TMO);
    chk("lim_fault", last_fault, 0);
    chk("lim_ReadData", ReadData_o, 32'hFFFF_8001);

    // Misaligned word load.
    txn(0, 3'b010, 32'h0000_0002, 32'h0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_fault", last_fault, 1);
    chk("mis_no_req", req_total - req_snap, 0);
    chk("mis_latency", done_cyc - txn_start, 1);
`else
    chk("mis_fault", last_fault, 0);
    chk("mis_addr", last_addr, 32'h0);
    chk("mis_be", last_be, 4'b1111);
    chk("mis_ReadData", ReadData_o, 32'hCAFE_F00D);
`endif

    // Further width/sign/lane patterns.
    txn(0, 3'b001, 32'h0000_0006, 32'h0, 32'h7FFF_0000, 0);
    txn(0, 3'b001, 32'h0000_0005, 32'h0, 32'h1234_F00D, 1);
    txn(0, 3'b100, 32'h0000_0002, 32'h0, 32'h00AB_0000, 0);
    chk("lbu_ReadData", ReadData_o, 32'h0000_00AB);
    txn(1, 3'b001, 32'h0000_000A, 32'hDEAD_BEEF, 32'h0, 0);
    chk("sh_wdata", last_wd, 32'hBEEF_BEEF);
    txn(1, 3'b010, 32'h0000_0020, 32'h0123_4567, 32'h0, 3);
    txn(0, 3'b011, 32'h0000_0044, 32'h0, 32'h89AB_CDEF, 0);
    txn(1, 3'b111, 32'h0000_0048, 32'h5A5A_0F0F, 32'h0, 1);
    txn(1, 3'b000, 32'h0000_0050, 32'h0000_0077, 32'h0, -1);

    // Reset asserted during REQ, followed by a late ack.
    step();
    req_valid = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h40; bus_ack = 0;
    clear_exp(); e_stall = 1;
    step();
    clear_exp(); e_stall = 1; e_req = 1; e_we = 0; e_addr = 32'h40; e_be = 4'hF;
    step();
    rst_n = 0; req_valid = 0;
    step();
    rst_n = 1; bus_ack = 1; bus_rdata = 32'h5555_AAAA; model_rd = 0;
    clear_exp(); e_zero = 1;
    step();
    bus_ack = 0;
    clear_exp(); e_zero = 1;
    done_cyc = -1;
    step();
    clear_exp(); e_zero = 1;
    chk("rst_no_done", done_cyc, -1);

    // Next request proceeds normally.
    txn(0, 3'b000, 32'h0000_0061, 32'h0, 32'h0000_7F00, 0);
    chk("post_rst_ReadData", ReadData_o, 32'h0000_007F);
    chk("post_rst_latency", done_cyc - txn_start, 2);

    step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_port.md
# lsu_mem_port

Multi-cycle load/store port between the core datapath and the data-memory bus. It accepts one load or store per transaction, drives a request/acknowledge bus with byte enables, and returns the aligned, sign- or zero-extended `ReadData` word consumed by the writeback select. It stalls the core while a transaction is outstanding and reports bus timeouts (and, optionally, misaligned accesses) as faults.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64, maximum number of cycles in REQ waiting for `bus_ack` before a fault is raised (range 1..255).

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `req_valid`  in  1  core requests a memory operation; held stable until `done`.
- `mem_write`  in  1  1 = store, 0 = load.
- `funct3`  in  3  access width/sign: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2).
- `stall`  out  1  core must hold the pipeline.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  valid with `done`; transaction failed.
- `ReadData`  out  32  load result; valid with `done`, held until next `done`.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  bus write enable.
- `bus_addr`  out  32  word address ({addr[31:2],2'b00}).
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_be`  out  4  byte enables.
- `bus_ack`  in  1  bus completion.
- `bus_rdata`  in  32  bus read data, valid with `bus_ack`.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: on `req_valid`, latch `addr`, `wdata`, `funct3`, `mem_write`; go to REQ; clear timeout counter.
- REQ: `bus_req`=1; bus outputs driven from latched values, stable throughout. On `bus_ack`: loads register extracted `bus_rdata`; go to RESP. Counter increments each REQ cycle without ack; when it reaches `TIMEOUT_CYCLES`: go to RESP with fault, `ReadData`=0.
- RESP: `done`=1 for one cycle, `fault` as determined; next state IDLE. `req_valid` in RESP is ignored (next request accepted from IDLE).
- `stall` = (IDLE and `req_valid`) or REQ. Low in RESP.
- Store lanes: byte: `bus_be`=4'b0001<<addr[1:0], `bus_wdata`={4{wdata[7:0]}}; half: `bus_be`=4'b0011<<{addr[1],1'b0}, `bus_wdata`={2{wdata[15:0]}}; word: `bus_be`=4'b1111, `bus_wdata`=`wdata`.
- Loads: `bus_be` per width as above, `bus_we`=0. Data = `bus_rdata`>>(addr[1:0]*8), then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) from byte/half.
- Undefined funct3 (011, 110, 111): treated as word access.
- `bus_ack` outside REQ is ignored.

## Timing
- Reset (synchronous, `rst_n`=0 at rising edge): state IDLE, counter 0, `bus_req`, `bus_we`, `done`, `fault`, `stall` deasserted, `bus_addr`, `bus_wdata`, `bus_be`, `ReadData` = 0.
- Reset mid-transaction: `bus_req` drops at that edge; a later `bus_ack` is ignored; no `done`.
- Best-case latency: request seen in IDLE at cycle 0, `bus_req` cycle 1, ack in cycle 1, `done` cycle 2.
- Timeout: `done`/`fault` exactly `TIMEOUT_CYCLES`+1 cycles after REQ entry.
- `bus_ack` on the same cycle the counter hits the limit: the ack wins, no fault.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: half access with addr[0]=1 or word access with addr[1:0]≠0 goes IDLE→RESP directly, `fault`=1, `ReadData`=0, no `bus_req`; `done` one cycle after acceptance.
- Undefined: no misalignment check; half accesses use addr[1] only (addr[0] ignored), word accesses ignore addr[1:0].

## Test plan
- Load byte signed: addr=0x103, bus_rdata=0x80FF_0012 with ack on first REQ cycle -> `done` at cycle 2, `ReadData`=0xFFFF_FF80, `bus_be`=4'b1000, `bus_addr`=0x100.
- Load half unsigned: addr=0x202, bus_rdata=0xBEEF_1234 -> `ReadData`=0x0000_BEEF, `bus_be`=4'b1100.
- Store byte: addr=0x001, wdata=0x1234_56AB -> `bus_we`=1, `bus_be`=4'b0010, `bus_wdata`=0xABAB_ABAB; `stall` high until RESP.
- Timeout: `TIMEOUT_CYCLES`=4, no ack -> `done`&`fault` after 5 REQ-relative cycles, `ReadData`=0, `bus_req` low in RESP.
- Misaligned word load addr=0x002: with `LSU_MISALIGN_TRAP_EN` -> `fault`=1, no `bus_req`; without -> `bus_addr`=0x000, `bus_be`=4'b1111, no fault.
- Reset asserted in REQ, then ack next cycle -> no `done`, all outputs 0, next request proceeds normally.
